// File: rtl/align_pkg.sv
// align_pkg: shared default widths and the per-beat payload type for the
// pipelined alignment datapath.
package align_pkg;

  localparam int MANT_W = 24;
  localparam int OUT_W  = 61;
  localparam int DIFF_W = 8;
  localparam int PSH_W  = 6;

  // One beat as it travels between stages: aligned magnitude, the sign
  // still to be applied, and the sticky flag gathered during the right shift.
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sign;
    logic             sticky;
  } beat_t;

endpackage

// File: rtl/pipelined_align_unit_cond_negate.sv
// cond_negate: combinational two's-complement negation selected by neg_i.
// Negating zero wraps back to zero because the sum is truncated to W bits.
module cond_negate #(
  parameter int W = 61
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  localparam logic [W-1:0] ONE = W'(1);

  // Select the input or its modulo-2^W negation.
  always_comb begin
    data_o = data_i;
    if (neg_i) data_o = (~data_i) + ONE;
  end

endmodule

// File: rtl/pipelined_align_unit.sv
// pipelined_align_unit: three-stage mantissa aligner with valid/ready flow
// control. Stage 1 pre-shifts the mantissa left into the OUT_W frame,
// stage 2 right-shifts by the exponent difference, stage 3 applies the
// sign by conditional negation.
// Optional feature: define ALIGN_STICKY_EN to produce out_sticky (OR of the
// bits lost in the right shift); otherwise out_sticky is tied to 0.
module pipelined_align_unit #(
  parameter int MANT_W = align_pkg::MANT_W,
  parameter int OUT_W  = align_pkg::OUT_W,
  parameter int DIFF_W = align_pkg::DIFF_W,
  parameter int PSH_W  = align_pkg::PSH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [DIFF_W-1:0] in_diff,
  input  logic [PSH_W-1:0]  in_pshift,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sticky
);

  import align_pkg::*;

  // Local payload with the same layout as align_pkg::beat_t, sized by OUT_W.
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sign;
    logic             sticky;
  } pay_t;

`ifdef ALIGN_STICKY_EN
  // True when any bit of x falls below the shift point; a shift of OUT_W or
  // more makes the mask all ones, so every bit of x counts as lost.
  function automatic logic lost_bits(input logic [OUT_W-1:0] x,
                                     input logic [DIFF_W-1:0] sh);
    logic [OUT_W-1:0] mask;
    mask = ~({OUT_W{1'b1}} << sh);
    return |(x & mask);
  endfunction
`endif

  logic              vld_p1_q, vld_p2_q, vld_p3_q;
  logic              en_p1, en_p2, en_p3;

  logic [OUT_W-1:0]  x1_d;
  logic [OUT_W-1:0]  x1_p1_q;
  logic [DIFF_W-1:0] diff_p1_q;
  logic              sign_p1_q;

  pay_t              pay_p2_d, pay_p2_q;

  logic [OUT_W-1:0]  neg_data;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_sticky_q;

  // A stage may load when it is empty or its content leaves this cycle;
  // the chain runs combinationally from out_ready back to in_ready.
  always_comb begin
    en_p3 = !vld_p3_q || out_ready;
    en_p2 = !vld_p2_q || en_p3;
    en_p1 = !vld_p1_q || en_p2;
  end

  assign in_ready  = en_p1;
  assign out_valid = vld_p3_q;

  // ---- stage 1: zero-extend and pre-shift left into the output frame
  assign x1_d = {{(OUT_W-MANT_W){1'b0}}, in_mant} << in_pshift;

  // Stage 1 register: takes a new beat whenever it has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      x1_p1_q   <= '0;
      diff_p1_q <= '0;
      sign_p1_q <= 1'b0;
    end else if (en_p1) begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        x1_p1_q   <= x1_d;
        diff_p1_q <= in_diff;
        sign_p1_q <= in_sign;
      end
    end
  end

  // ---- stage 2: right shift by the exponent difference, gather sticky
  always_comb begin
    pay_p2_d      = '0;
    pay_p2_d.sign = sign_p1_q;
    if (int'(diff_p1_q) < OUT_W) pay_p2_d.data = x1_p1_q >> diff_p1_q;
`ifdef ALIGN_STICKY_EN
    pay_p2_d.sticky = lost_bits(x1_p1_q, diff_p1_q);
`endif
  end

  // Stage 2 register: advances the shifted magnitude with its sign and sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      pay_p2_q <= '0;
    end else if (en_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) pay_p2_q <= pay_p2_d;
    end
  end

  // ---- stage 3: apply the sign
  cond_negate #(
    .W (OUT_W)
  ) u_neg (
    .data_i (pay_p2_q.data),
    .neg_i  (pay_p2_q.sign),
    .data_o (neg_data)
  );

  // Output register: holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3_q     <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
    end else if (en_p3) begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        out_data_q   <= neg_data;
        out_sticky_q <= pay_p2_q.sticky;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_sticky = out_sticky_q;

endmodule

// File: tb/tb_pipelined_align_unit.sv
// Bench for pipelined_align_unit: driver pushes expected results into a
// queue on every accepted beat; a negedge monitor compares each presented
// output with the queue head and pops it when the consumer takes it.
module tb_pipelined_align_unit;
  import align_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [MANT_W-1:0]  in_mant;
  logic [DIFF_W-1:0]  in_diff;
  logic [PSH_W-1:0]   in_pshift;
  logic               in_sign;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_sticky;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  beat_t exp_q[$];

  pipelined_align_unit #(
    .MANT_W (MANT_W),
    .OUT_W  (OUT_W),
    .DIFF_W (DIFF_W),
    .PSH_W  (PSH_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_diff    (in_diff),
    .in_pshift  (in_pshift),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: arithmetic on wide integers straight from the alignment rules.
  function automatic beat_t model(input logic [MANT_W-1:0] m, input logic [DIFF_W-1:0] d,
                                  input logic [PSH_W-1:0] p, input logic s);
    logic [127:0] modv, x1, x2, rem, pw;
    beat_t        r;
    modv = 128'd1 << OUT_W;
    x1   = (128'(m) * (128'd1 << p)) % modv;
    if (int'(d) >= OUT_W) begin
      x2  = '0;
      rem = x1;
    end else begin
      pw  = 128'd1 << d;
      x2  = x1 / pw;
      rem = x1 % pw;
    end
    if (s) x2 = (modv - x2) % modv;
    r.data = x2[OUT_W-1:0];
    r.sign = s;
`ifdef ALIGN_STICKY_EN
    r.sticky = (rem != '0);
`else
    r.sticky = 1'b0;
`endif
    return r;
  endfunction

  // Present one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [MANT_W-1:0] m, input logic [DIFF_W-1:0] d,
                      input logic [PSH_W-1:0] p, input logic s, input beat_t e);
    bit done = 0;
    in_mant = m; in_diff = d; in_pshift = p; in_sign = s; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic send_rand();
    logic [MANT_W-1:0] m;
    logic [DIFF_W-1:0] d;
    logic [PSH_W-1:0]  p;
    logic              s;
    m = MANT_W'($urandom);
    d = ($urandom_range(0, 7) == 0) ? DIFF_W'($urandom) : DIFF_W'($urandom_range(0, 70));
    p = PSH_W'($urandom);
    s = 1'($urandom);
    send(m, d, p, s, model(m, d, p, s));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  // Monitor: compare every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out actual=%0h required=no_output", out_data);
      end else begin
        chk("out_data", 128'(out_data), 128'(exp_q[0].data));
        chk("out_sticky", 128'(out_sticky), 128'(exp_q[0].sticky));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    beat_t e;
    int    c0;
    bit    rnd_done;
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_diff = '0; in_pshift = '0;
    in_sign = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_out_sticky", 128'(out_sticky), 128'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Latency: result visible after the third edge following acceptance.
    send(24'h123456, 8'd3, 6'd5, 1'b0, model(24'h123456, 8'd3, 6'd5, 1'b0));
    @(negedge clk); chk("lat_c1", 128'(out_valid), 128'd0);
    @(negedge clk); chk("lat_c2", 128'(out_valid), 128'd0);
    @(negedge clk); chk("lat_c3", 128'(out_valid), 128'd1);
    wait_drain();

    // Directed corner vectors with literal expected values.
    e.sign = 1'b0; e.sticky = 1'b0; e.data = 61'h1FFFFFE000000000;
    send(24'hFFFFFF, 8'd0, 6'd37, 1'b0, e);
    e.sign = 1'b1; e.sticky = 1'b0; e.data = 61'h1FFFFFFFFFFFFFFF;
    send(24'h000001, 8'd0, 6'd0, 1'b1, e);
    e.sign = 1'b0; e.data = '0;
`ifdef ALIGN_STICKY_EN
    e.sticky = 1'b1;
`else
    e.sticky = 1'b0;
`endif
    send(24'h800000, 8'd40, 6'd10, 1'b0, e);
    e.sign = 1'b1; e.data = '0;
    send(24'h000003, 8'd200, 6'd0, 1'b1, e);
    e.sign = 1'b1; e.sticky = 1'b0; e.data = '0;
    send(24'h000000, 8'd0, 6'd0, 1'b1, e);
    wait_drain();

    // Throughput: eight back-to-back beats take eight cycles.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_rand();
    chk("throughput_cycles", 128'(cyc - c0), 128'd8);
    wait_drain();

    // Backpressure: three beats fill the pipe, the fourth waits.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    in_mant = 24'h00ABCD; in_diff = 8'd2; in_pshift = 6'd20; in_sign = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    fork
      send(24'h00ABCD, 8'd2, 6'd20, 1'b1, model(24'h00ABCD, 8'd2, 6'd20, 1'b1));
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); chk("bp_burst_valid", 128'(out_valid), 128'd1);
      end
    join
    wait_drain();

    // Reset with beats in flight: they must vanish.
    out_ready = 1'b0;
    send(24'hABCDEF, 8'd0, 6'd0, 1'b0, model(24'hABCDEF, 8'd0, 6'd0, 1'b0));
    send(24'h654321, 8'd1, 6'd4, 1'b1, model(24'h654321, 8'd1, 6'd4, 1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_flight_valid", 128'(out_valid), 128'd0);
    chk("rst_flight_data", 128'(out_data), 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_flight_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Random traffic with random consumer stalls.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_align_unit.md
PIPELINED_ALIGN_UNIT -- requirements
Module: pipelined_align_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MANT_W, default 24, SHALL set the mantissa input width.
REQ-003 Parameter OUT_W, default 61, SHALL set the aligned-output width; OUT_W SHALL be greater than MANT_W.
REQ-004 Parameter DIFF_W, default 8, SHALL set the exponent-difference width.
REQ-005 Parameter PSH_W, default 6, SHALL set the precision pre-shift width.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  input beat present.
REQ-009 in_ready  out  1  block accepts the input beat this cycle.
REQ-010 in_mant  in  MANT_W  unsigned mantissa.
REQ-011 in_diff  in  DIFF_W  right-shift amount (exponent difference).
REQ-012 in_pshift  in  PSH_W  left pre-shift amount (precision-mode placement).
REQ-013 in_sign  in  1  1 means the output is two's-complement negated.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_data  out  OUT_W  aligned, conditionally negated result.
REQ-017 out_sticky  out  1  OR of all nonzero bits lost in the right shift.

Function
REQ-018 Stage 1 SHALL register x1 = zero-extend(in_mant) << in_pshift, truncated to OUT_W; bits shifted past bit OUT_W-1 are dropped.
REQ-019 Stage 2 SHALL register x2 = x1 >> in_diff; if in_diff >= OUT_W, then x2 = 0.
REQ-020 Stage 3 SHALL register out_data = in_sign ? (2^OUT_W - x2) mod 2^OUT_W : x2; negation of 0 SHALL yield 0.
REQ-021 in_sign and sticky SHALL travel with their beat through every stage.
REQ-022 Latency SHALL be 3 cycles from accepted input to out_valid when out_ready is held high; throughput SHALL be 1 beat per cycle.
REQ-023 A beat SHALL transfer on an interface when valid and ready are both high at a rising edge.
REQ-024 Stage k SHALL load when it is empty or its content moves to stage k+1 in the same cycle; otherwise it SHALL hold its content.
REQ-025 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle; the ready path SHALL be combinational.
REQ-026 With out_ready low, the pipeline SHALL hold up to 3 beats, preserving order, with no loss or duplication.
REQ-027 out_data and out_sticky SHALL remain stable while out_valid is high and out_ready is low.
REQ-028 A simultaneous input accept and output drain on a full pipeline SHALL complete in one cycle with no bubble.

Reset
REQ-029 On rst, all stage valid flags, out_valid, out_data and out_sticky SHALL be 0 at the next edge.
REQ-030 All data registers SHALL reset to 0.
REQ-031 Beats in flight when rst is asserted SHALL be discarded.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-033 With macro ALIGN_STICKY_EN defined, out_sticky SHALL equal the OR of the bits of x1 shifted out by in_diff (all of x1 when in_diff >= OUT_W).
REQ-034 Without ALIGN_STICKY_EN, out_sticky SHALL be tied to 0 and no sticky logic SHALL be synthesised.

Structure
REQ-035 The shared package align_pkg SHALL hold the default width constants MANT_W, OUT_W, DIFF_W and PSH_W, and the stage-payload struct type (data, sign, sticky).
REQ-036 Conditional negation SHALL live in sub-module cond_negate (OUT_W-parametrised, combinational), instantiated in stage 3.

Verification
REQ-037 mant=0xFFFFFF, pshift=37, diff=0, sign=0 -> after 3 cycles out_data=0x1FFFFFE000000000, sticky=0.
REQ-038 mant=1, pshift=0, diff=0, sign=1 -> out_data=0x1FFFFFFFFFFFFFFF (all ones).
REQ-039 mant=0x800000, pshift=10, diff=40, sign=0 -> out_data=0; sticky=1 with ALIGN_STICKY_EN and 0 without it.
REQ-040 mant=0x000003, pshift=0, diff=200, sign=1 -> out_data=0, sticky=1 (with ALIGN_STICKY_EN).
REQ-041 Push 4 beats with out_ready=0 for 6 cycles -> in_ready=0 after 3 beats are accepted; on release the 4 results emerge in order, one per cycle.
REQ-042 Assert rst with 2 beats in flight -> next cycle out_valid=0, out_data=0; no stale beat appears after release.
